// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver. The asynchronous uart_rx pin is synchronised,
//   deserialised LSB-first by a small bit-timing FSM, and complete bytes are
//   queued in a show-ahead FIFO read by the CPU.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   uart_rx    in   serial line, idle high, asynchronous to clk
//   rd_en      in   pop the FIFO head (ignored while rx_valid = 0)
//   clr_err    in   clear frame_err and overrun
//   rx_data    out  FIFO head byte, meaningful while rx_valid = 1
//   rx_valid   out  FIFO non-empty
//   rx_irq     out  level interrupt request, equal to rx_valid
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_irq,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]      HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]      BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Synchroniser; both flops reset to the idle line level.
    logic sync1_q, sync2_q;
    logic rxs;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;

    logic               push_req;
    logic               frame_set;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               pop, full, do_push, overrun_set;

    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    assign rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // Bit-timing FSM. Tests are written as "!rxs" / "rxs" so an unknown
    // line level leaves the receiver idle rather than starting a frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so it cannot produce bytes.
                if (rxs) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // FIFO control. A simultaneous pop frees a slot, so a push into a full
    // FIFO still succeeds in that case.
    always_comb begin
        pop         = rd_en && (count_q != '0);
        full        = (count_q == FULL_COUNT);
        do_push     = push_req && (!full || pop);
        overrun_set = push_req && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so rx_data reads 0 afterwards.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[gi] <= '0;
            end else if (do_push && (wr_ptr_q == FIFO_AW'(gi))) begin
                mem_q[gi] <= shift_q;
            end
        end
    end

    // Sticky flags: a set event on the same edge as clr_err wins.
    always_comb begin
        frame_err_d = frame_set   || (frame_err_q && !clr_err);
        overrun_d   = overrun_set || (overrun_q   && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = (count_q != '0);
    assign rx_irq    = rx_valid;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Drives 8N1 frames onto uart_rx and compares the receiver against a
//   queue-based model of the byte buffer and its sticky flags.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_irq;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_irq   (rx_irq),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned model_q[$];
    bit           model_fe = 1'b0;
    bit           model_ov = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_valid"}, rx_valid, model_q.size() != 0);
        check_eq({tag, "_irq"}, rx_irq, model_q.size() != 0);
        check_eq({tag, "_ferr"}, frame_err, model_fe);
        check_eq({tag, "_ovr"}, overrun, model_ov);
    endtask

    task automatic pop_check(input string tag);
        if (model_q.size() == 0) begin
            check_eq({tag, "_empty"}, rx_valid, 1'b0);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end else begin
            check_eq({tag, "_valid"}, rx_valid, 1'b1);
            check_eq({tag, "_data"}, rx_data, model_q[0]);
            $display("pop   %02h (expected %02h)", rx_data, model_q[0]);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(model_q.pop_front());
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        model_fe = 1'b0;
        model_ov = 1'b0;
    endtask

    // One frame: start bit, 8 data bits LSB-first, stop bit of the given
    // level and length. Optionally pops on the stop-sample edge (10 clocks
    // into the stop bit plus the 2-flop synchroniser delay from the start
    // alignment) or pulses reset during a data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl = 1'b1,
                             input int stop_len = CPB, input bit pop_at_stop = 1'b0,
                             input int reset_bit = -1);
        bit saw_valid;
        bit was_empty;
        bit did_reset;
        did_reset = 1'b0;
        $display("frame %02h stop=%0d len=%0d", b, stop_lvl, stop_len);
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            for (int k = 0; k < CPB; k++) begin
                if (i == reset_bit && k == 5) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    model_q.delete();
                    model_fe = 1'b0;
                    model_ov = 1'b0;
                    did_reset = 1'b1;
                    check_eq("rst_mid_valid", rx_valid, 1'b0);
                    check_eq("rst_mid_ferr", frame_err, 1'b0);
                    check_eq("rst_mid_ovr", overrun, 1'b0);
                    check_eq("rst_mid_data", rx_data, 8'h00);
                end else begin
                    tick();
                end
            end
        end
        uart_rx   = stop_lvl;
        was_empty = (model_q.size() == 0);
        saw_valid = 1'b0;
        for (int k = 0; k < stop_len; k++) begin
            if (pop_at_stop && k == 10) begin
                check_eq("stop_pop_head", rx_data, model_q[0]);
                rd_en = 1'b1;
            end
            tick();
            if (pop_at_stop && k == 10) begin
                void'(model_q.pop_front());
            end
            rd_en = 1'b0;
            if (!stop_lvl && rx_valid) saw_valid = 1'b1;
        end
        uart_rx = 1'b1;
        if (did_reset) begin
            // Remainder of an aborted frame must not yield a byte.
        end else if (stop_lvl) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else model_ov = 1'b1;
        end else begin
            model_fe = 1'b1;
            if (was_empty) check_eq("no_byte_in_break", saw_valid, 1'b0);
        end
    endtask

    initial begin
        int n;
        int lat_exp;
        logic [7:0] rb;

        reset   = 1'b1;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_state("reset");
        check_eq("reset_data", rx_data, 8'h00);

        // 1: single byte, latency from the line falling to rx_valid
        lat_exp = 2 + CPB / 2 + 9 * CPB + 1;
        n = 0;
        fork
            send_byte(8'h55);
            begin
                while (!rx_valid && n < 400) begin
                    tick();
                    n++;
                end
            end
        join
        check_eq("t1_latency", n, lat_exp);
        check_state("t1");
        pop_check("t1_pop");
        check_eq("t1_valid_after_pop", rx_valid, 1'b0);

        // 2: five back-to-back bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check_state("t2_full");
        for (int i = 0; i < 4; i++) pop_check("t2_pop");
        pop_check("t2_drained");
        pulse_clr();
        check_state("t2_clr");

        // 3: full FIFO, pop on the stop-sample edge of the fifth byte
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_byte(8'hA5, 1'b1, CPB, 1'b1);
        check_state("t3");
        for (int i = 0; i < 4; i++) pop_check("t3_pop");
        pop_check("t3_drained");

        // 4: short low glitch is rejected
        uart_rx = 1'b0;
        repeat (4) tick();
        idle(30);
        check_state("t4_glitch");
        send_byte(8'hC3);
        check_state("t4");
        pop_check("t4_pop");

        // 5: stop bit held low, then a good frame
        send_byte(8'h3C, 1'b0, 40);
        idle(5);
        check_state("t5_break");
        send_byte(8'h7E);
        check_state("t5");

        // 6: reset during the data bits with two bytes queued
        send_byte(8'($urandom));
        check_state("t6_pre");
        send_byte(8'hFF, 1'b1, CPB, 1'b0, 3);
        idle(5);
        check_state("t6_after");
        send_byte(8'h11);
        check_state("t6");
        pop_check("t6_pop");

        // Random traffic: random bytes, gaps, reads and flag clears
        for (int t = 0; t < 40; t++) begin
            idle($urandom_range(0, 20));
            rb = 8'($urandom);
            send_byte(rb);
            if ($urandom_range(0, 2) == 0) pop_check("rnd_pop");
            if ($urandom_range(0, 7) == 0) pulse_clr();
            check_state("rnd");
        end
        while (model_q.size() != 0) pop_check("rnd_drain");
        pop_check("rnd_empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 serial receiver: deserializes the asynchronous `uart_rx` pin and buffers received bytes in a small show-ahead FIFO for the CPU's I/O read path.
- Sits directly upstream of the CPU inside `computer`.
- Raises `rx_irq` while data is pending, for use as an `intr` source.
- Reports sticky framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit. Even, ≥4. 16 matches the 160-time-unit bit period at the 10-unit clock.
- FIFO_AW, 2, FIFO address width. Depth = 2**FIFO_AW = 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rd_en  in  1  pop FIFO head. Ignored when rx_valid=0.
- clr_err  in  1  clears frame_err and overrun.
- rx_data  out  8  FIFO head byte. Valid only when rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_irq  out  1  equals rx_valid (level interrupt request).
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (clk edge with reset=1):
  - Both synchronizer flops = 1; FSM = IDLE; bit counter and bit index = 0.
  - FIFO pointers and count = 0, so rx_valid = rx_irq = 0.
  - frame_err = overrun = 0; rx_data = 0.
  - Reset mid-frame abandons the partial byte, discards FIFO contents, and takes priority over every other event.
- Synchronizer: 2 flops on uart_rx. `rxs` = second flop.
  - An X or undriven uart_rx after reset must not corrupt state: rxs becomes known once the pin is driven.
- FSM (counter `cnt` increments every clock in the non-IDLE states and resets to 0 on every state change or sample):
  - IDLE: rxs=0 -> START, cnt=0.
  - START: at cnt = CLKS_PER_BIT/2-1, sample rxs.
    - 0 -> DATA, bit index 0.
    - 1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt = CLKS_PER_BIT-1, shift rxs into the shift register LSB-first and increment the index.
    - After the 8th sample -> STOP.
  - STOP: at cnt = CLKS_PER_BIT-1, sample rxs.
    - 1 -> push byte, go to IDLE.
    - 0 -> set frame_err, discard byte, go to BREAK.
  - BREAK: remain until rxs=1, then IDLE. A held-low line never produces bytes.
- Push: on the stop-sample edge; the FIFO updates on that edge.
  - With an empty FIFO, rx_valid rises 1 clock later.
  - Latency from the first clk edge sampling uart_rx=0 to rx_valid=1 is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks (155 at default).
- FIFO: show-ahead, rx_data = mem[rd_ptr] combinationally. Pointers wrap modulo depth; count is FIFO_AW+1 bits.
  - Pop: rd_en=1 and count>0 advances rd_ptr on that edge; the new head appears the following cycle.
  - Push with count=depth and no same-cycle pop: byte dropped, overrun set, FIFO unchanged.
  - Push and pop on the same edge: both happen, count unchanged, no overrun (also when full).
  - Pop when empty: no effect; pointers stay put.
- Flags:
  - clr_err=1 clears both flags on that edge.
  - If a set event coincides with clr_err, set wins.
  - Flags do not affect reception.

Test Plan:
1. Reset, line idle high, send 0x55 at 16 clk/bit -> rx_valid rises exactly 155 clocks after the start-bit edge; rx_data=0x55; rx_irq=1; flags 0. Pulse rd_en -> rx_valid=0 next cycle.
2. Send 0x01,0x02,0x03,0x04,0x05 back-to-back with no reads -> count=4, overrun=1, then pops return 0x01..0x04 in order and rx_valid=0 after the 4th. Pulse clr_err -> overrun=0.
3. FIFO full, assert rd_en on the exact stop-sample edge of a 5th byte 0xA5 -> no overrun; pops return 0x02,0x03,0x04,0xA5.
4. Low glitch of 4 clocks on idle line -> FSM returns to IDLE, rx_valid stays 0, flags 0. Then send 0xC3 -> received correctly.
5. Frame 0x3C with stop bit held low for 40 clocks -> frame_err=1, no push, no byte during the low period. After the line rises, send 0x7E -> received as 0x7E.
6. Reset asserted for 1 clock during the DATA bits of 0xFF with 2 bytes queued -> rx_valid=0 and flags 0 the next cycle; the remainder of the aborted frame yields no byte; the next full frame 0x11 is received correctly.
